// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing, retire counter.
// Optional load-linked/store-conditional support is compiled in with `define LLSC_EN.
module mc_control_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegWr,
    output logic              BrEq,
    output logic              BrNeq,
    output logic              Jump,
    output logic              RegToPc,
    output logic              Halt,
    output logic              sc_success,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             is_jr, is_branch, is_mem, is_load;

    assign is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) || is_jr;
    assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_LL) || (opcode == OP_SC);
    assign is_load   = (opcode == OP_LW) || (opcode == OP_LL);

`ifdef LLSC_EN
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic              sc_q, sc_d;
    logic              sc_ok;

    assign sc_ok = link_valid_q && (daddr == link_addr_q);
`else
    logic unused_llsc;
    assign unused_llsc = ^{snoop_valid, snoop_addr, daddr};
`endif

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        iREN    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        RegWr   = 1'b0;
        BrEq    = 1'b0;
        BrNeq   = 1'b0;
        Jump    = 1'b0;
        RegToPc = 1'b0;
        Halt    = 1'b0;
`ifdef LLSC_EN
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        sc_d         = sc_q;
`endif
        case (state_q)
            FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    IRWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = (opcode == OP_HALT) ? HALTED : EXEC;
            EXEC: begin
                BrEq    = (opcode == OP_BEQ);
                BrNeq   = (opcode == OP_BNE);
                Jump    = (opcode == OP_J) || (opcode == OP_JAL);
                RegToPc = is_jr;
                if (is_mem) begin
                    state_d = MEM;
                end else if (is_branch) begin
                    PCWrite = 1'b1;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (is_load) begin
                    dREN = 1'b1;
                    if (dhit) begin
                        state_d = WB;
`ifdef LLSC_EN
                        if (opcode == OP_LL) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = daddr;
                        end
`endif
                    end
`ifdef LLSC_EN
                end else if (opcode == OP_SC) begin
                    // A failed link check skips the bus write and retires in one cycle.
                    if (sc_ok) begin
                        dWEN = 1'b1;
                        if (dhit) begin
                            state_d      = WB;
                            sc_d         = 1'b1;
                            link_valid_d = 1'b0;
                        end
                    end else begin
                        state_d      = WB;
                        sc_d         = 1'b0;
                        link_valid_d = 1'b0;
                    end
`endif
                end else begin
                    dWEN = 1'b1;
                    if (dhit) begin
                        PCWrite = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                RegWr   = 1'b1;
                PCWrite = 1'b1;
                state_d = FETCH;
            end
            HALTED: Halt = 1'b1;
            default: state_d = FETCH;
        endcase

`ifdef LLSC_EN
        // Comparing against the next link address lets a snoop beat a same-cycle LL.
        if (snoop_valid && (snoop_addr == link_addr_d)) begin
            link_valid_d = 1'b0;
        end
`endif

        if (RST) begin
            iREN    = 1'b0;
            dREN    = 1'b0;
            dWEN    = 1'b0;
            IRWrite = 1'b0;
            PCWrite = 1'b0;
            RegWr   = 1'b0;
            Halt    = 1'b0;
        end

        if (PCWrite) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= FETCH;
            instr_count_q <= '0;
`ifdef LLSC_EN
            link_valid_q  <= 1'b0;
            link_addr_q   <= '0;
            sc_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
`ifdef LLSC_EN
            link_valid_q  <= link_valid_d;
            link_addr_q   <= link_addr_d;
            sc_q          <= sc_d;
`endif
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;
`ifdef LLSC_EN
    assign sc_success  = sc_q;
`else
    assign sc_success  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit (CNT_W=4); expectations follow LLSC_EN when defined.
module tb_mc_control_unit;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;
    localparam logic [5:0] OP_SC    = 6'h38;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        ihit = 1'b0;
    logic        dhit = 1'b0;
    logic [31:0] daddr = '0;
    logic        snoop_req = 1'b0;
    logic        snoop_co = 1'b0;
    logic [31:0] snoop_addr_req = '0;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        iREN, dREN, dWEN, IRWrite, PCWrite, RegWr;
    logic        BrEq, BrNeq, Jump, RegToPc, Halt, sc_success;
    logic [2:0]  state;
    logic [3:0]  instr_count;

    assign snoop_valid = snoop_req | snoop_co;
    assign snoop_addr  = snoop_co ? daddr : snoop_addr_req;

    mc_control_unit #(.ADDR_W(32), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .ihit(ihit), .dhit(dhit),
        .daddr(daddr), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWr(RegWr), .BrEq(BrEq), .BrNeq(BrNeq), .Jump(Jump), .RegToPc(RegToPc),
        .Halt(Halt), .sc_success(sc_success), .state(state), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       regwr;
        logic       sc;
        logic [3:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    logic [3:0] model_cnt = '0;

    // Memory responder: ihit/dhit after iwait/dwait request cycles
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    bit spam = 1'b0, snoop_on_dhit = 1'b0;
    initial forever begin
        @(posedge CLK); #2;
        snoop_co = 1'b0;
        if (spam) ihit = ~ihit;
        else if (iREN && icnt == iwait) begin ihit = 1'b1; icnt = 0; end
        else begin ihit = 1'b0; icnt = iREN ? icnt + 1 : 0; end
        if ((dREN || dWEN) && dcnt == dwait) begin
            dhit = 1'b1; dcnt = 0; snoop_co = snoop_on_dhit;
        end else begin
            dhit = 1'b0; dcnt = (dREN || dWEN) ? dcnt + 1 : 0;
        end
    end

    // Monitor: scoreboard pops on every retire, plus per-instruction activity counters
    int mem_cyc, dren_cyc, dwen_cyc, iren_cyc, breq_cyc, brne_cyc, jmp_cyc, rtp_cyc, irw_at;
    int retire_cnt = 0;
    int trace_q[$];
    exp_t e;
    always @(negedge CLK) begin
        if (PCWrite) begin
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 32'(PCWrite), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("retire_regwr", 32'(RegWr), 32'(e.regwr));
                chk("retire_count", 32'(instr_count), 32'(e.cnt));
                chk("retire_sc_success", 32'(sc_success), 32'(e.sc));
            end
            retire_cnt++;
        end
        chk("req_exclusive", 32'(iREN & (dREN | dWEN)), 32'd0);
        if (IRWrite && irw_at < 0) irw_at = trace_q.size();
        trace_q.push_back(int'(state));
        if (state == 3'd3) mem_cyc++;
        if (dREN) dren_cyc++;
        if (dWEN) dwen_cyc++;
        if (iREN) iren_cyc++;
        if (BrEq) breq_cyc++;
        if (BrNeq) brne_cyc++;
        if (Jump) jmp_cyc++;
        if (RegToPc) rtp_cyc++;
    end

    task automatic clear_counters();
        mem_cyc = 0; dren_cyc = 0; dwen_cyc = 0; iren_cyc = 0;
        breq_cyc = 0; brne_cyc = 0; jmp_cyc = 0; rtp_cyc = 0; irw_at = -1;
        trace_q.delete();
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the retire edge
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] addr,
                             input int iw, input int dw, input logic regwr, input logic sc);
        int start;
        opcode = op; funct = fn; daddr = addr; iwait = iw; dwait = dw;
        clear_counters();
        exp_q.push_back('{regwr: regwr, sc: sc, cnt: model_cnt});
        model_cnt = model_cnt + 4'd1;
        start = retire_cnt;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            if (retire_cnt != start) break;
        end
        chk("retire_timeout", 32'(retire_cnt - start), 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        model_cnt = '0;
        exp_q.delete();
    endtask

    int exp_tr[6] = '{0, 0, 0, 1, 2, 4};

    initial begin
        clear_counters();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_sc", 32'(sc_success), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        run_instr(OP_ADDIU, 6'h00, 32'h0, 2, 0, 1'b1, 1'b0);
        chk("addiu_trace_len", 32'(trace_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < trace_q.size(); i++) chk("addiu_trace", 32'(trace_q[i]), 32'(exp_tr[i]));
        chk("addiu_irwrite_cycle", 32'(irw_at), 32'd2);
        chk("addiu_back_to_fetch", 32'(state), 32'd0);
        chk("addiu_count", 32'(instr_count), 32'd1);

        run_instr(OP_LW, 6'h00, 32'h40, 0, 3, 1'b1, 1'b0);
        chk("lw_dren_cycles", 32'(dren_cyc), 32'd4);
        chk("lw_mem_cycles", 32'(mem_cyc), 32'd4);
        run_instr(OP_SW, 6'h00, 32'h44, 0, 1, 1'b0, 1'b0);
        chk("sw_dwen_cycles", 32'(dwen_cyc), 32'd2);
        chk("sw_dren_cycles", 32'(dren_cyc), 32'd0);
        run_instr(OP_BEQ, 6'h00, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("beq_breq", 32'(breq_cyc), 32'd1);
        chk("beq_mem", 32'(mem_cyc), 32'd0);
        run_instr(OP_BNE, 6'h00, 32'h0, 1, 0, 1'b0, 1'b0);
        chk("bne_brneq", 32'(brne_cyc), 32'd1);
        chk("bne_breq", 32'(breq_cyc), 32'd0);
        run_instr(OP_J, 6'h00, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("j_jump", 32'(jmp_cyc), 32'd1);
        run_instr(OP_RTYPE, FN_JR, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("jr_regtopc", 32'(rtp_cyc), 32'd1);
        run_instr(OP_RTYPE, FN_ADDU, 32'h0, 0, 0, 1'b1, 1'b0);
        chk("addu_regtopc", 32'(rtp_cyc), 32'd0);
        run_instr(OP_LUI, 6'h00, 32'h0, 0, 0, 1'b1, 1'b0);

        // LL then SC to the same address
        run_instr(OP_LL, 6'h00, 32'h100, 0, 1, 1'b1, 1'b0);
        chk("ll_dren_cycles", 32'(dren_cyc), 32'd2);
        run_instr(OP_SC, 6'h00, 32'h100, 0, 1, LLSC, LLSC);
        chk("sc_ok_dwen_cycles", 32'(dwen_cyc), 32'd2);
        // LL, intervening snoop, SC
        run_instr(OP_LL, 6'h00, 32'h100, 0, 0, 1'b1, LLSC);
        snoop_addr_req = 32'h100; snoop_req = 1'b1;
        @(posedge CLK); #1;
        snoop_req = 1'b0;
        run_instr(OP_SC, 6'h00, 32'h100, 0, 1, LLSC, 1'b0);
        chk("sc_snooped_dwen", 32'(dwen_cyc), LLSC ? 32'd0 : 32'd2);
        chk("sc_snooped_mem", 32'(mem_cyc), LLSC ? 32'd1 : 32'd2);
        // Snoop coincident with LL completion
        snoop_on_dhit = 1'b1;
        run_instr(OP_LL, 6'h00, 32'h100, 0, 1, 1'b1, 1'b0);
        snoop_on_dhit = 1'b0;
        run_instr(OP_SC, 6'h00, 32'h100, 0, 1, LLSC, 1'b0);
        chk("sc_coincident_dwen", 32'(dwen_cyc), LLSC ? 32'd0 : 32'd2);
        run_instr(OP_LL, 6'h00, 32'h100, 0, 0, 1'b1, 1'b0);
        run_instr(OP_SC, 6'h00, 32'h100, 0, 0, LLSC, LLSC);
        chk("sc_relink_dwen", 32'(dwen_cyc), 32'd1);
        chk("count_after_17", 32'(instr_count), 32'd1);

        // Reset while a load is waiting on dhit
        opcode = OP_LW; funct = '0; daddr = 32'h80; iwait = 0; dwait = 20;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (dREN) break;
        end
        chk("midrst_dren_seen", 32'(dREN), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_dren_drop", 32'(dREN), 32'd0);
        chk("midrst_no_pcwrite", 32'(PCWrite), 32'd0);
        chk("midrst_no_regwr", 32'(RegWr), 32'd0);
        do_reset();
        RST = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_count", 32'(instr_count), 32'd0);
        chk("midrst_sc", 32'(sc_success), 32'd0);

        // HALT is sticky against ihit activity
        opcode = OP_HALT; dwait = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (state == 3'd5) break;
        end
        chk("halt_state", 32'(state), 32'd5);
        @(negedge CLK);
        chk("halt_flag", 32'(Halt), 32'd1);
        @(posedge CLK); #1;
        clear_counters();
        spam = 1'b1;
        repeat (20) @(posedge CLK);
        #1 spam = 1'b0;
        @(negedge CLK);
        chk("halt_sticky_state", 32'(state), 32'd5);
        chk("halt_no_iren", 32'(iren_cyc), 32'd0);
        chk("halt_no_irwrite", 32'(irw_at), 32'hFFFF_FFFF);
        chk("halt_count", 32'(instr_count), 32'(model_cnt));
        @(posedge CLK); #1;
        do_reset();
        RST = 1'b0;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_count", 32'(instr_count), 32'd0);

        // 17 retires on a 4-bit counter wrap to 1
        for (int i = 0; i < 17; i++) run_instr(OP_ADDIU, 6'h00, 32'h0, 0, 0, 1'b1, 1'b0);
        chk("wrap_count", 32'(instr_count), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
